// File: rtl/lsu_master.sv
// Load/store unit bus master: takes one memory-stage request, issues a single
// word-addressed bus transfer, and for loads waits for the read data, then
// aligns and extends it.
//
// Handshake: mem_req is high exactly while a transfer is pending and a
// transfer happens on the first cycle where mem_req and mem_ready are both 1;
// mem_we/mem_addr/mem_wdata/mem_be are held stable until then. Read data is
// taken only on a cycle with mem_rvalid=1 while waiting for a response; any
// other mem_rvalid is ignored.
module lsu_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  info_load,
    input  logic [1:0]  info_store,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    // FSM state for observation: 0 idle, 1 request pending, 2 awaiting read data
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t      state, state_nxt;

    logic        is_store;
    logic        is_load;
    logic [1:0]  size_code;   // 0 byte, 1 half, 2 word
    logic [1:0]  offset;
    logic        misaligned;
    logic        accept;
    logic [3:0]  be_req;

    logic [2:0]  ld_kind;
    logic [1:0]  ld_off;
    logic [31:0] rdata_shift;
    logic [31:0] ld_ext;

    // Decode the incoming request; a store takes priority over a load.
    always_comb begin
        offset    = alu_result[1:0];
        is_store  = (info_store != 2'd0);
        is_load   = !is_store && (info_load >= 3'd1) && (info_load <= 3'd5);
        size_code = 2'd0;
        if (is_store) begin
            size_code = info_store - 2'd1;
        end else begin
            case (info_load)
                3'd1, 3'd4: size_code = 2'd0;
                3'd2, 3'd5: size_code = 2'd1;
                default:    size_code = 2'd2;
            endcase
        end
        misaligned = ((size_code == 2'd1) && (offset == 2'd3)) ||
                     ((size_code == 2'd2) && (offset != 2'd0));
        accept     = (state == IDLE) && req_valid && (is_store || is_load);
        be_req     = 4'hF;
        if (is_store) begin
            case (size_code)
                2'd0:    be_req = 4'b0001 << offset;
                2'd1:    be_req = 4'b0011 << offset;
                default: be_req = 4'hF;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and state-derived outputs.
    always_comb begin
        state_nxt = state;
        mem_req   = (state == REQ);
        stall     = (state != IDLE);
        state_dbg = state;
        case (state)
            IDLE:    if (accept && !misaligned) state_nxt = REQ;
            REQ:     if (mem_ready) state_nxt = mem_we ? IDLE : WAIT_R;
            WAIT_R:  if (mem_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Align the returned word to the requested byte and extend it.
    always_comb begin
        rdata_shift = mem_rdata >> {ld_off, 3'b000};
        case (ld_kind)
            3'd1:    ld_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'd2:    ld_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'd4:    ld_ext = {24'd0, rdata_shift[7:0]};
            3'd5:    ld_ext = {16'd0, rdata_shift[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Request capture, single-cycle pulses and load result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            load_data  <= 32'd0;
            mem_we     <= 1'b0;
            mem_addr   <= 30'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            ld_kind    <= 3'd0;
            ld_off     <= 2'd0;
        end else begin
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            if (accept) begin
                if (misaligned) begin
                    misalign <= 1'b1;
                end else begin
                    mem_we    <= is_store;
                    mem_addr  <= alu_result[31:2];
                    mem_be    <= be_req;
                    mem_wdata <= is_store ? (rs2 << {offset, 3'b000}) : 32'd0;
                    ld_kind   <= info_load;
                    ld_off    <= offset;
                end
            end
            if ((state == WAIT_R) && mem_rvalid) begin
                load_valid <= 1'b1;
                load_data  <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_master.sv
// Self-checking bench for lsu_master: directed cases followed by randomized
// transactions compared against a byte-level model of the load/store rules.
module tb_lsu_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  info_load;
    logic [1:0]  info_store;
    logic [31:0] alu_result;
    logic [31:0] rs2;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  state_dbg;

    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;
    int          lv_count = 0;
    logic [31:0] last_ld = 32'd0;

    lsu_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .info_load  (info_load),
        .info_store (info_store),
        .alu_result (alu_result),
        .rs2        (rs2),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .misalign   (misalign),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .state_dbg  (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    // Count completed writes and load_valid pulses.
    always @(posedge clk) begin
        if (!rst && mem_req && mem_ready && mem_we) wr_count++;
        if (load_valid) lv_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: access width in bytes, 0 when there is no operation.
    function automatic int op_bytes(input logic [1:0] st, input logic [2:0] ld);
        if (st != 0) return (st == 3) ? 4 : int'(st);
        case (ld)
            3'd1, 3'd4: return 1;
            3'd2, 3'd5: return 2;
            3'd3:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input int off, input int n, input bit is_st);
        logic [3:0] be = 4'd0;
        if (!is_st) return 4'hF;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input int off, input logic [31:0] d, input bit is_st);
        logic [31:0] w = 32'd0;
        if (!is_st) return 32'd0;
        for (int i = 0; i < 4; i++) if (i >= off) w[8*i +: 8] = d[8*(i-off) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input int off, input int n, input logic [2:0] ld,
                                               input logic [31:0] rd);
        logic [31:0] v = 32'd0;
        for (int b = 0; b < n; b++) v[8*b +: 8] = rd[8*(off+b) +: 8];
        if ((ld == 3'd1 || ld == 3'd2) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // Drive random junk on the request inputs while the unit is busy.
    task automatic drive_junk_req();
        req_valid  = 1'($urandom_range(0, 1));
        info_store = 2'($urandom_range(0, 3));
        info_load  = 3'($urandom_range(0, 7));
        alu_result = $urandom;
        rs2        = $urandom;
    endtask

    // One transaction. Starts and ends just after a falling edge.
    task automatic run_txn(input logic [1:0] st, input logic [2:0] ld, input logic [31:0] addr,
                           input logic [31:0] data, input int rdy_dly, input int rv_dly,
                           input logic [31:0] rdata);
        int          n;
        int          off;
        bit          is_st;
        int          wr0;
        int          lv0;
        logic [31:0] exp;
        n     = op_bytes(st, ld);
        off   = int'(addr[1:0]);
        is_st = (st != 0);
        wr0   = wr_count;
        lv0   = lv_count;
        req_valid = 1'b1; info_store = st; info_load = ld; alu_result = addr; rs2 = data;
        @(negedge clk);
        if (n == 0) begin
            req_valid = 1'b0;
            check("noop_misalign", 32'(misalign), 32'd0);
            check("noop_stall", 32'(stall), 32'd0);
            check("noop_ld_hold", load_data, last_ld);
            return;
        end
        if (off + n > 4) begin
            req_valid = 1'b0;
            check("mis_pulse", 32'(misalign), 32'd1);
            check("mis_stall", 32'(stall), 32'd0);
            check("mis_req", 32'(mem_req), 32'd0);
            @(negedge clk);
            check("mis_once", 32'(misalign), 32'd0);
            check("mis_req2", 32'(mem_req), 32'd0);
            check("mis_nowrite", 32'(wr_count - wr0), 32'd0);
            check("mis_ld_hold", load_data, last_ld);
            return;
        end
        check("acc_misalign", 32'(misalign), 32'd0);
        for (int c = 0; c <= rdy_dly; c++) begin
            check("req_stall", 32'(stall), 32'd1);
            check("req_req", 32'(mem_req), 32'd1);
            check("req_we", 32'(mem_we), 32'(is_st));
            check("req_addr", 32'(mem_addr), 32'(addr[31:2]));
            check("req_be", 32'(mem_be), 32'(model_be(off, n, is_st)));
            check("req_wdata", mem_wdata, model_wdata(off, data, is_st));
            drive_junk_req();
            mem_ready  = (c == rdy_dly);
            mem_rvalid = (c == rdy_dly) ? 1'b0 : 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            @(negedge clk);
        end
        mem_ready = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
        check("wr_count", 32'(wr_count - wr0), 32'(is_st));
        if (is_st) begin
            check("st_stall_drop", 32'(stall), 32'd0);
            check("st_req_drop", 32'(mem_req), 32'd0);
            check("st_no_lv", 32'(lv_count - lv0), 32'd0);
            check("st_ld_hold", load_data, last_ld);
            return;
        end
        for (int c = 0; c <= rv_dly; c++) begin
            check("wr_stall", 32'(stall), 32'd1);
            check("wr_req", 32'(mem_req), 32'd0);
            check("wr_lv", 32'(load_valid), 32'd0);
            drive_junk_req();
            mem_rvalid = (c == rv_dly);
            mem_rdata  = (c == rv_dly) ? rdata : $urandom;
            @(negedge clk);
        end
        mem_rvalid = 1'b0; req_valid = 1'b0;
        exp = model_load(off, n, ld, rdata);
        check("ld_valid", 32'(load_valid), 32'd1);
        check("ld_data", load_data, exp);
        check("ld_stall", 32'(stall), 32'd0);
        last_ld = exp;
        @(negedge clk);
        check("ld_pulse", 32'(load_valid), 32'd0);
        check("ld_hold", load_data, last_ld);
        check("ld_one", 32'(lv_count - lv0), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_lv"}, 32'(load_valid), 32'd0);
        check({tag, "_mis"}, 32'(misalign), 32'd0);
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_be"}, 32'(mem_be), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_ldata"}, load_data, 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    // Reset while awaiting read data; a late mem_rvalid must be ignored.
    task automatic reset_in_wait();
        int lv0;
        req_valid = 1'b1; info_store = 2'd0; info_load = 3'd3; alu_result = 32'h20; rs2 = 32'd0;
        @(negedge clk);
        req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rw_in_wait", 32'(stall), 32'd1);
        lv0 = lv_count;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        check_all_zero("rw_rst");
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_all_zero("rw_after");
        @(negedge clk);
        check("rw_no_lv", 32'(lv_count - lv0), 32'd0);
        last_ld = 32'd0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; info_load = 3'd0; info_store = 2'd0;
        alu_result = 32'd0; rs2 = 32'd0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed: byte store, half loads (signed/unsigned), stalled word
        // store, misaligned word load, store+load together.
        run_txn(2'd1, 3'd0, 32'h102, 32'h0000_00AB, 0, 0, 32'd0);
        run_txn(2'd0, 3'd2, 32'h202, 32'd0, 0, 0, 32'h8001_1234);
        run_txn(2'd0, 3'd5, 32'h202, 32'd0, 1, 2, 32'h8001_1234);
        run_txn(2'd3, 3'd0, 32'h40, 32'hCAFE_F00D, 3, 0, 32'd0);
        run_txn(2'd0, 3'd3, 32'h6, 32'd0, 0, 0, 32'd0);
        run_txn(2'd3, 3'd3, 32'h10, 32'h1234_5678, 0, 0, 32'd0);
        run_txn(2'd0, 3'd1, 32'h303, 32'd0, 0, 0, 32'h80FF_0000);
        run_txn(2'd2, 3'd0, 32'h3, 32'hFFFF, 0, 0, 32'd0);
        reset_in_wait();

        // Randomized transactions.
        for (int i = 0; i < 200; i++) begin
            logic [1:0] st;
            st = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            run_txn(st, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
